// File: rtl/dma_copy_engine_pkg.sv
// Shared constants, FSM state types and helpers for the DMA copy engine.
package dma_copy_engine_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_DATA} wr_state_t;

    // AXI size encoding: log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int unsigned dwidth);
        logic [2:0] s;
        s = 3'd0;
        for (int unsigned b = dwidth / 8; b > 1; b = b / 2) s = s + 3'd1;
        return s;
    endfunction

    // Beats in the next burst: whatever is left, capped at the burst limit.
    function automatic logic [31:0] burst_beats(input logic [31:0] remaining,
                                                input int unsigned max_burst);
        return (remaining > 32'(max_burst)) ? 32'(max_burst) : remaining;
    endfunction

endpackage

// File: rtl/dma_copy_engine_sync_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != (PW+1)'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; no reset needed, contents are only read behind the count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers and count; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_copy_engine.sv
// Memory-to-memory copy engine: splits a copy into INCR bursts, buffers read
// data in a FIFO and replays it as write bursts of the same shape.
module dma_copy_engine #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32,
    parameter int MAX_BURST  = 256,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AXI_AWIDTH-1:0] cmd_src_addr,
    input  logic [AXI_AWIDTH-1:0] cmd_dst_addr,
    input  logic [31:0]           cmd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  core_read_request_valid,
    input  logic                  core_read_request_ready,
    output logic [AXI_AWIDTH-1:0] core_read_addr,
    output logic [31:0]           core_read_len,
    output logic [2:0]            core_read_size,
    output logic [1:0]            core_read_burst,
    input  logic [AXI_DWIDTH-1:0] core_read_data,
    input  logic                  core_read_data_valid,
    output logic                  core_read_data_ready,
    output logic                  core_write_request_valid,
    input  logic                  core_write_request_ready,
    output logic [AXI_AWIDTH-1:0] core_write_addr,
    output logic [31:0]           core_write_len,
    output logic [2:0]            core_write_size,
    output logic [1:0]            core_write_burst,
    output logic [AXI_DWIDTH-1:0] core_write_data,
    output logic                  core_write_data_valid,
    input  logic                  core_write_data_ready
);
    import dma_copy_engine_pkg::*;

    localparam int BPW = AXI_DWIDTH / 8;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int LW  = $clog2(MAX_BURST) + 1;

    rd_state_t             rd_state;
    wr_state_t             wr_state;
    logic [AXI_AWIDTH-1:0] rd_addr, wr_addr;
    logic [31:0]           rd_rem, wr_rem;
    logic [LW-1:0]         rd_left, wr_left;
    logic [31:0]           rd_beats, wr_beats;
    logic [31:0]           fifo_free, reserved;
    logic [CW-1:0]         fifo_count;
    logic                  start, rd_push, wr_pop, wr_last;

    assign cmd_ready        = !busy;
    assign start            = cmd_valid && cmd_ready && (cmd_len != 32'd0);
    assign core_read_size   = axi_size(AXI_DWIDTH);
    assign core_write_size  = axi_size(AXI_DWIDTH);
    assign core_read_burst  = AXI_BURST_INCR;
    assign core_write_burst = AXI_BURST_INCR;

    assign rd_beats = burst_beats(rd_rem, MAX_BURST);
    assign wr_beats = burst_beats(wr_rem, MAX_BURST);

    // Beats already promised to the FIFO by the read burst in flight.
    assign reserved  = (rd_state == R_DATA) ? 32'(rd_left) : 32'd0;
    assign fifo_free = 32'(FIFO_DEPTH) - 32'(fifo_count);

    assign core_read_data_ready  = (rd_state == R_DATA);
    assign core_write_data_valid = (wr_state == W_DATA);
    assign rd_push = core_read_data_ready && core_read_data_valid;
    assign wr_pop  = core_write_data_valid && core_write_data_ready;
    assign wr_last = wr_pop && (wr_left == LW'(1)) && (wr_rem == 32'd0);

    sync_fifo #(.WIDTH(AXI_DWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_push),
        .push_data (core_read_data),
        .pop       (wr_pop),
        .pop_data  (core_write_data),
        .count     (fifo_count)
    );

    // Command accept and completion; a zero-length copy completes without going busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                if (cmd_len == 32'd0) done <= 1'b1;
                else                  busy <= 1'b1;
            end else if (wr_last) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    // Read FSM: request a burst only once the FIFO can absorb all of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state                <= R_IDLE;
            core_read_request_valid <= 1'b0;
            core_read_addr          <= '0;
            core_read_len           <= '0;
            rd_addr                 <= '0;
            rd_rem                  <= '0;
            rd_left                 <= '0;
        end else begin
            case (rd_state)
                R_IDLE: if (start) begin
                    rd_addr  <= cmd_src_addr;
                    rd_rem   <= cmd_len;
                    rd_state <= R_REQ;
                end
                R_REQ: if (core_read_request_valid) begin
                    if (core_read_request_ready) begin
                        core_read_request_valid <= 1'b0;
                        rd_left  <= LW'(rd_beats);
                        rd_addr  <= rd_addr + AXI_AWIDTH'(rd_beats * BPW);
                        rd_rem   <= rd_rem - rd_beats;
                        rd_state <= R_DATA;
                    end
                end else if (fifo_free - reserved >= rd_beats) begin
                    core_read_request_valid <= 1'b1;
                    core_read_addr          <= rd_addr;
                    core_read_len           <= rd_beats - 32'd1;
                end
                R_DATA: if (core_read_data_valid) begin
                    rd_left <= rd_left - LW'(1);
                    if (rd_left == LW'(1)) rd_state <= (rd_rem == 32'd0) ? R_IDLE : R_REQ;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: request a burst once the FIFO holds every beat of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state                 <= W_IDLE;
            core_write_request_valid <= 1'b0;
            core_write_addr          <= '0;
            core_write_len           <= '0;
            wr_addr                  <= '0;
            wr_rem                   <= '0;
            wr_left                  <= '0;
        end else begin
            case (wr_state)
                W_IDLE: if (start) begin
                    wr_addr  <= cmd_dst_addr;
                    wr_rem   <= cmd_len;
                    wr_state <= W_REQ;
                end
                W_REQ: if (core_write_request_valid) begin
                    if (core_write_request_ready) begin
                        core_write_request_valid <= 1'b0;
                        wr_left  <= LW'(wr_beats);
                        wr_addr  <= wr_addr + AXI_AWIDTH'(wr_beats * BPW);
                        wr_rem   <= wr_rem - wr_beats;
                        wr_state <= W_DATA;
                    end
                end else if (32'(fifo_count) >= wr_beats) begin
                    core_write_request_valid <= 1'b1;
                    core_write_addr          <= wr_addr;
                    core_write_len           <= wr_beats - 32'd1;
                end
                W_DATA: if (core_write_data_ready) begin
                    wr_left <= wr_left - LW'(1);
                    if (wr_left == LW'(1)) wr_state <= (wr_rem == 32'd0) ? W_IDLE : W_REQ;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Randomised bench for dma_copy_engine with a transaction-level model of the
// burst plan, FIFO occupancy and source memory contents.
module tb_dma_copy_engine;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MAXB  = 256;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid, cmd_ready, busy, done;
    logic [AW-1:0] cmd_src_addr, cmd_dst_addr;
    logic [31:0]   cmd_len;
    logic          core_read_request_valid, core_read_request_ready;
    logic [AW-1:0] core_read_addr;
    logic [31:0]   core_read_len;
    logic [2:0]    core_read_size;
    logic [1:0]    core_read_burst;
    logic [DW-1:0] core_read_data;
    logic          core_read_data_valid, core_read_data_ready;
    logic          core_write_request_valid, core_write_request_ready;
    logic [AW-1:0] core_write_addr;
    logic [31:0]   core_write_len;
    logic [2:0]    core_write_size;
    logic [1:0]    core_write_burst;
    logic [DW-1:0] core_write_data;
    logic          core_write_data_valid, core_write_data_ready;

    dma_copy_engine #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .MAX_BURST(MAXB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
        .busy(busy), .done(done),
        .core_read_request_valid(core_read_request_valid),
        .core_read_request_ready(core_read_request_ready),
        .core_read_addr(core_read_addr), .core_read_len(core_read_len),
        .core_read_size(core_read_size), .core_read_burst(core_read_burst),
        .core_read_data(core_read_data), .core_read_data_valid(core_read_data_valid),
        .core_read_data_ready(core_read_data_ready),
        .core_write_request_valid(core_write_request_valid),
        .core_write_request_ready(core_write_request_ready),
        .core_write_addr(core_write_addr), .core_write_len(core_write_len),
        .core_write_size(core_write_size), .core_write_burst(core_write_burst),
        .core_write_data(core_write_data), .core_write_data_valid(core_write_data_valid),
        .core_write_data_ready(core_write_data_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] beats; } burst_t;

    burst_t      exp_rd_q[$], exp_wr_q[$], rd_run_q[$], wr_run_q[$], obs_rd_q[$], obs_wr_q[$];
    int          n_chk = 0, n_fail = 0;
    int          done_cnt = 0, n_rreq = 0;
    logic [31:0] rd_idx, wr_idx, rd_recv, wr_sent, total;
    logic [31:0] src_base, dst_base, seed;
    bit          active, exp_done, gaps, hold_wr;
    bit          cmd_pend;
    logic [31:0] cmd_s, cmd_d, cmd_l;
    bit          rreq_wait, wreq_wait;
    logic [31:0] rreq_addr_p, rreq_len_p, wreq_addr_p, wreq_len_p;

    // Source memory contents are a hash of the byte address.
    function automatic logic [31:0] src_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Expected burst list: min(remaining, MAXB) beats each, address advancing by 4*beats.
    function automatic void plan(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        logic [31:0] rem, sa, da, b;
        rem = l; sa = s; da = d;
        while (rem != 0) begin
            b = (rem > 32'(MAXB)) ? 32'(MAXB) : rem;
            exp_rd_q.push_back('{sa, b});
            exp_wr_q.push_back('{da, b});
            sa = sa + b * 32'd4;
            da = da + b * 32'd4;
            rem = rem - b;
        end
    endfunction

    function automatic void model_reset();
        exp_rd_q.delete(); exp_wr_q.delete(); rd_run_q.delete(); wr_run_q.delete();
        rd_idx = 0; wr_idx = 0; rd_recv = 0; wr_sent = 0; total = 0;
        active = 0; exp_done = 0; rreq_wait = 0; wreq_wait = 0; cmd_pend = 0;
    endfunction

    function automatic void quiet_inputs();
        cmd_valid = 0; cmd_src_addr = 0; cmd_dst_addr = 0; cmd_len = 0;
        core_read_request_ready = 0; core_read_data = 0; core_read_data_valid = 0;
        core_write_request_ready = 0; core_write_data_ready = 0;
    endfunction

    // One clock: check outputs against the model, drive inputs, then account
    // for the handshakes that the coming rising edge will complete.
    task automatic step();
        burst_t      h;
        logic [31:0] occ, outst, ea;
        @(negedge clk);
        chk("busy", busy, active);
        chk("done", done, exp_done);
        chk("cmd_ready", cmd_ready, !active);
        chk("rd_data_ready", core_read_data_ready, rd_run_q.size() != 0);
        chk("wr_data_valid", core_write_data_valid, wr_run_q.size() != 0);
        if (done) done_cnt++;
        occ = rd_recv - wr_sent;
        outst = 0;
        foreach (rd_run_q[i]) outst = outst + rd_run_q[i].beats;
        outst = outst - rd_idx;
        if (rreq_wait) begin
            chk("rreq_hold_valid", core_read_request_valid, 1);
            chk("rreq_hold_addr", core_read_addr, rreq_addr_p);
            chk("rreq_hold_len", core_read_len, rreq_len_p);
        end
        if (wreq_wait) begin
            chk("wreq_hold_valid", core_write_request_valid, 1);
            chk("wreq_hold_addr", core_write_addr, wreq_addr_p);
            chk("wreq_hold_len", core_write_len, wreq_len_p);
        end
        if (core_read_request_valid) begin
            chk("rreq_expected", exp_rd_q.size() != 0, 1);
            chk("rreq_size", core_read_size, 3'd2);
            chk("rreq_burst", core_read_burst, 2'b01);
            if (exp_rd_q.size() != 0)
                chk("rreq_credit", (occ + outst + exp_rd_q[0].beats) <= 32'(DEPTH), 1);
        end
        if (core_write_request_valid) begin
            chk("wreq_expected", exp_wr_q.size() != 0, 1);
            chk("wreq_size", core_write_size, 3'd2);
            chk("wreq_burst", core_write_burst, 2'b01);
            if (exp_wr_q.size() != 0)
                chk("wreq_fifo_has_burst", occ >= exp_wr_q[0].beats, 1);
        end

        cmd_valid = cmd_pend; cmd_src_addr = cmd_s; cmd_dst_addr = cmd_d; cmd_len = cmd_l;
        core_read_request_ready  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        core_write_request_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        core_write_data_ready    = hold_wr ? 1'b0 : (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
        if (rd_run_q.size() != 0) begin
            core_read_data_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            core_read_data = src_word(rd_run_q[0].addr + rd_idx * 32'd4);
        end else begin
            core_read_data_valid = 1'b0;
            core_read_data = $urandom;
        end

        exp_done = 0;
        rreq_wait = core_read_request_valid && !core_read_request_ready;
        rreq_addr_p = core_read_addr; rreq_len_p = core_read_len;
        wreq_wait = core_write_request_valid && !core_write_request_ready;
        wreq_addr_p = core_write_addr; wreq_len_p = core_write_len;
        if (cmd_valid && cmd_ready) begin
            cmd_pend = 0;
            src_base = cmd_src_addr; dst_base = cmd_dst_addr; total = cmd_len;
            rd_recv = 0; wr_sent = 0;
            if (cmd_len == 0) exp_done = 1;
            else begin active = 1; plan(cmd_src_addr, cmd_dst_addr, cmd_len); end
        end
        if (core_read_data_valid && core_read_data_ready && rd_run_q.size() != 0) begin
            rd_idx = rd_idx + 1; rd_recv = rd_recv + 1;
            if (rd_idx == rd_run_q[0].beats) begin void'(rd_run_q.pop_front()); rd_idx = 0; end
        end
        if (core_read_request_valid && core_read_request_ready && exp_rd_q.size() != 0) begin
            h = exp_rd_q.pop_front();
            chk("rreq_addr", core_read_addr, h.addr);
            chk("rreq_len", core_read_len, h.beats - 1);
            rd_run_q.push_back(h);
            obs_rd_q.push_back('{core_read_addr, core_read_len + 32'd1});
            n_rreq++;
        end
        if (core_write_data_valid && core_write_data_ready && wr_run_q.size() != 0) begin
            ea = wr_run_q[0].addr + wr_idx * 32'd4;
            chk("wdata", core_write_data, src_word(src_base + (ea - dst_base)));
            wr_idx = wr_idx + 1; wr_sent = wr_sent + 1;
            if (wr_idx == wr_run_q[0].beats) begin void'(wr_run_q.pop_front()); wr_idx = 0; end
            if (wr_sent == total) begin active = 0; exp_done = 1; end
        end
        if (core_write_request_valid && core_write_request_ready && exp_wr_q.size() != 0) begin
            h = exp_wr_q.pop_front();
            chk("wreq_addr", core_write_addr, h.addr);
            chk("wreq_len", core_write_len, h.beats - 1);
            wr_run_q.push_back(h);
            obs_wr_q.push_back('{core_write_addr, core_write_len + 32'd1});
        end
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        seed = $urandom;
        obs_rd_q.delete(); obs_wr_q.delete(); n_rreq = 0;
        cmd_s = s; cmd_d = d; cmd_l = l; cmd_pend = 1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) step();
        chk(name, done_cnt - d0, 1);
    endtask

    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                           input int budget);
        issue(s, d, l);
        wait_done("done_within_budget", budget);
        chk("beats_written", wr_sent, l);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rreq_valid"}, core_read_request_valid, 0);
        chk({tag, "_wreq_valid"}, core_write_request_valid, 0);
        chk({tag, "_wdata_valid"}, core_write_data_valid, 0);
        chk({tag, "_rdata_ready"}, core_read_data_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        logic [31:0] s, d, l;
        quiet_inputs();
        model_reset();
        gaps = 0; hold_wr = 0; seed = 0;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk) rst = 0;

        // single short burst
        run_cmd(32'h1000, 32'h2000, 32'd4, 100);
        chk("t1_nrd", obs_rd_q.size(), 1);
        chk("t1_rd0_addr", obs_rd_q[0].addr, 32'h1000);
        chk("t1_rd0_beats", obs_rd_q[0].beats, 4);
        chk("t1_nwr", obs_wr_q.size(), 1);
        chk("t1_wr0_addr", obs_wr_q[0].addr, 32'h2000);
        chk("t1_wr0_beats", obs_wr_q[0].beats, 4);

        // split into a full burst plus a tail
        run_cmd(32'h1000, 32'h2000, 32'd300, 1500);
        chk("t2_nrd", obs_rd_q.size(), 2);
        chk("t2_rd0_addr", obs_rd_q[0].addr, 32'h1000);
        chk("t2_rd0_beats", obs_rd_q[0].beats, 256);
        chk("t2_rd1_addr", obs_rd_q[1].addr, 32'h1400);
        chk("t2_rd1_beats", obs_rd_q[1].beats, 44);
        chk("t2_wr0_addr", obs_wr_q[0].addr, 32'h2000);
        chk("t2_wr1_addr", obs_wr_q[1].addr, 32'h2400);
        chk("t2_wr1_beats", obs_wr_q[1].beats, 44);

        // random back-pressure on every handshake
        gaps = 1;
        run_cmd(32'h8000, 32'h9000, 32'd64, 2000);
        gaps = 0;

        // zero-length copy
        issue(32'h1000, 32'h2000, 32'd0);
        wait_done("t4_done", 3);
        chk("t4_nrd", obs_rd_q.size(), 0);
        repeat (5) step();

        // writes stalled: credit limits reads to two full bursts
        hold_wr = 1;
        issue(32'h10000, 32'h20000, 32'd1024);
        repeat (800) step();
        chk("t5_rd_bursts_stalled", n_rreq, 2);
        chk("t5_fifo_full", rd_recv - wr_sent, 512);
        hold_wr = 0;
        wait_done("t5_done", 3000);
        chk("t5_rd_bursts_total", n_rreq, 4);

        // reset in the middle of a copy
        issue(32'h1000, 32'h2000, 32'd300);
        repeat (320) step();
        #2 rst = 1;
        #1 check_idle_outputs("async_rst");
        quiet_inputs();
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", done, 0);
        end
        rst = 0;
        run_cmd(32'h3000, 32'h4000, 32'd4, 100);

        // random commands
        for (int t = 0; t < 4; t++) begin
            gaps = ($urandom_range(0, 1) == 1);
            s = {16'h0, $urandom_range(0, 16'h3FFF) * 4};
            d = 32'h0010_0000 + {16'h0, $urandom_range(0, 16'h3FFF) * 4};
            l = $urandom_range(1, 700);
            run_cmd(s, d, l, int'(l) * 8 + 200);
        end
        gaps = 0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
